direction_scheduler: RTL and testbench

DIRECTION_SCHEDULER -- requirements
Module: direction_scheduler

---
 rtl/direction_scheduler.sv | 167 ++++++++++++++++
 tb/tb_direction_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/direction_scheduler.sv
// direction_scheduler
//
// Turns debounced direction buttons into a snake-style heading. Presses are
// detected on rising edges and resolved by priority U > L > R > D. A press is
// legal when it differs from, and is not opposite to, the reference direction.
// Legal presses wait in a pending store until a game step (TICK) moves the
// oldest one into DIR.
//
// Configuration macro: DIR_QUEUE_EN
//   defined   : DEPTH-entry FIFO of pending directions. The reference is the
//               newest entry, or DIR when the FIFO is empty. A legal press
//               that finds the FIFO full with no pop pulses DROP.
//   undefined : a single pending slot. A newer legal press, checked against
//               DIR only, overwrites it. COUNT is 0 or 1, DROP is tied to 0
//               and DEPTH is ignored.
//
// Ports
//   CLK    in   system clock, rising edge
//   RESET  in   synchronous, active-high reset
//   BTNU   in   up button    (direction 0)
//   BTNL   in   left button  (direction 1)
//   BTNR   in   right button (direction 2)
//   BTND   in   down button  (direction 3)
//   TICK   in   one-cycle game-step strobe
//   DIR    out  current direction: UP=0, LEFT=1, RIGHT=2, DOWN=3
//   MOVE   out  registered one-cycle pulse, one cycle after each TICK
//   COUNT  out  number of pending entries
//   DROP   out  registered one-cycle pulse when a legal press is discarded
//
// Timing: a press sampled on an edge is visible in COUNT after that edge.
// A TICK sampled on an edge updates DIR and raises MOVE after that edge.
// There is no bypass: a press and a pop in the same cycle never hand the
// new press straight to DIR.
module direction_scheduler #(
    parameter int DEPTH = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTNU,
    input  logic       BTNL,
    input  logic       BTNR,
    input  logic       BTND,
    input  logic       TICK,
    output logic [1:0] DIR,
    output logic       MOVE,
    output logic [2:0] COUNT,
    output logic       DROP
);

    if (!(DEPTH == 2 || DEPTH == 4)) begin : g_bad_depth
        $error("direction_scheduler: DEPTH must be 2 or 4");
    end

    // The bit index of each button is its direction encoding.
    logic [3:0] btns;
    logic [3:0] btn_prev;
    logic [3:0] press;

    assign btns  = {BTND, BTNR, BTNL, BTNU};
    assign press = btns & ~btn_prev;

    // Keep only the highest-priority press. Lower-priority presses in the
    // same cycle are ignored, even if the winning press later turns out to
    // be illegal.
    logic       press_valid;
    logic [1:0] press_dir;

    always_comb begin
        press_valid = 1'b1;
        press_dir   = 2'd0;
        if (press[0])      press_dir = 2'd0;
        else if (press[1]) press_dir = 2'd1;
        else if (press[2]) press_dir = 2'd2;
        else if (press[3]) press_dir = 2'd3;
        else               press_valid = 1'b0;
    end

    logic [1:0] ref_dir;
    logic       legal;
    logic       pop;

    // The encodings are chosen so that opposite directions are bitwise
    // complements (0<->3, 1<->2), i.e. they sum to 3.
    assign legal = press_valid && (press_dir != ref_dir) && (press_dir != ~ref_dir);
    assign pop   = TICK && (COUNT != 3'd0);

`ifdef DIR_QUEUE_EN

    localparam int PW = $clog2(DEPTH);

    logic [1:0]    queue [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] newest_ptr;
    logic          full;
    logic          push;
    logic          drop_next;

    // The pointers wrap naturally because DEPTH is a power of two.
    assign newest_ptr = wr_ptr - PW'(1);
    assign ref_dir    = (COUNT != 3'd0) ? queue[newest_ptr] : DIR;
    assign full       = (COUNT == 3'(DEPTH));
    // A full queue can still take a press when the same cycle pops.
    assign push       = legal && (!full || pop);
    assign drop_next  = legal && full && !pop;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            DIR      <= 2'd0;
            MOVE     <= 1'b0;
            DROP     <= 1'b0;
            COUNT    <= 3'd0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            // Load history with the live buttons so a button held through
            // reset release does not count as a press.
            btn_prev <= btns;
        end else begin
            btn_prev <= btns;
            MOVE     <= TICK;
            DROP     <= drop_next;
            if (pop) begin
                DIR    <= queue[rd_ptr];
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push) begin
                queue[wr_ptr] <= press_dir;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            COUNT <= COUNT + 3'(push) - 3'(pop);
        end
    end

`else

    logic [1:0] slot_dir;

    assign ref_dir = DIR;
    assign DROP    = 1'b0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            DIR      <= 2'd0;
            MOVE     <= 1'b0;
            COUNT    <= 3'd0;
            slot_dir <= 2'd0;
            btn_prev <= btns;
        end else begin
            btn_prev <= btns;
            MOVE     <= TICK;
            if (pop) begin
                DIR <= slot_dir;
            end
            // A same-cycle press refills the slot after the pop, so the slot
            // stays occupied and the press waits for the next step.
            if (legal) begin
                slot_dir <= press_dir;
                COUNT    <= 3'd1;
            end else if (pop) begin
                COUNT    <= 3'd0;
            end
        end
    end

`endif

endmodule

// File: tb/tb_direction_scheduler.sv
// Bench for direction_scheduler. Directed scenarios followed by randomized
// traffic checked against a queue-based reference model of the scheduling
// rules. Works in both the DIR_QUEUE_EN and single-slot configurations.
module tb_direction_scheduler;

    localparam int DEPTH = 2;

    localparam logic [3:0] B_U = 4'b0001;
    localparam logic [3:0] B_L = 4'b0010;
    localparam logic [3:0] B_R = 4'b0100;
    localparam logic [3:0] B_D = 4'b1000;

    logic       CLK;
    logic       RESET;
    logic       BTNU, BTNL, BTNR, BTND;
    logic       TICK;
    logic [1:0] DIR;
    logic       MOVE;
    logic [2:0] COUNT;
    logic       DROP;

    int checks   = 0;
    int failures = 0;

    direction_scheduler #(.DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .BTNU  (BTNU),
        .BTNL  (BTNL),
        .BTNR  (BTNR),
        .BTND  (BTND),
        .TICK  (TICK),
        .DIR   (DIR),
        .MOVE  (MOVE),
        .COUNT (COUNT),
        .DROP  (DROP)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    logic [1:0] exp_q[$];
    logic [1:0] m_dir;
    logic [3:0] m_prev;
    logic       e_move;
    logic       e_drop;

    task automatic model_step(input logic rst, input logic [3:0] btn, input logic tick);
        logic [3:0] pr;
        int pd;
        int rf;
        int sz;
        bit lg;
        bit pp;
        pr     = btn & ~m_prev;
        m_prev = btn;
        if (rst) begin
            m_dir  = 2'd0;
            exp_q.delete();
            e_move = 1'b0;
            e_drop = 1'b0;
            return;
        end
        e_move = tick;
        e_drop = 1'b0;
        pd = -1;
        for (int i = 3; i >= 0; i--) if (pr[i]) pd = i;
        sz = exp_q.size();
`ifdef DIR_QUEUE_EN
        rf = (sz > 0) ? int'(exp_q[sz-1]) : int'(m_dir);
`else
        rf = int'(m_dir);
`endif
        lg = (pd >= 0) && (pd != rf) && (pd + rf != 3);
        pp = tick && (sz > 0);
        if (pp) m_dir = exp_q.pop_front();
`ifdef DIR_QUEUE_EN
        if (lg) begin
            if (sz < DEPTH || pp) exp_q.push_back(2'(pd));
            else e_drop = 1'b1;
        end
`else
        if (lg) begin
            exp_q.delete();
            exp_q.push_back(2'(pd));
        end
`endif
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic rst, input logic [3:0] btn, input logic tick);
        RESET = rst;
        {BTND, BTNR, BTNL, BTNU} = btn;
        TICK = tick;
        @(posedge CLK);
        model_step(rst, btn, tick);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        cycle(1'b1, B_L, 1'b0);
        cycle(1'b1, B_L, 1'b1);
        checks++;
        if (DIR !== 2'd0 || MOVE !== 1'b0 || COUNT !== 3'd0 || DROP !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: DIR=%0d MOVE=%0d COUNT=%0d DROP=%0d required 0 0 0 0",
                     DIR, MOVE, COUNT, DROP);
        end
        cycle(1'b0, B_L, 1'b0);
        cycle(1'b0, B_L, 1'b0);
        checks++;
        if (COUNT !== 3'd0 || DIR !== 2'd0) begin
            failures++;
            $display("FAIL reset_held_btn: COUNT=%0d DIR=%0d required 0 0", COUNT, DIR);
        end
        cycle(1'b0, 4'b0000, 1'b0);
    endtask

    task automatic test_reject_opposite;
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, B_D, 1'b0);
        checks++;
        if (COUNT !== 3'd0) begin
            failures++;
            $display("FAIL opposite_count: got %0d required 0", COUNT);
        end
        cycle(1'b0, 4'b0000, 1'b1);
        checks++;
        if (DIR !== 2'd0 || MOVE !== 1'b1) begin
            failures++;
            $display("FAIL opposite_tick: DIR=%0d MOVE=%0d required 0 1", DIR, MOVE);
        end
        cycle(1'b0, 4'b0000, 1'b0);
        checks++;
        if (MOVE !== 1'b0) begin
            failures++;
            $display("FAIL move_one_cycle: got %0d required 0", MOVE);
        end
    endtask

    task automatic test_two_presses;
        logic [2:0] c_after_u;
        logic [1:0] d_second;
        logic [2:0] c_first;
`ifdef DIR_QUEUE_EN
        c_after_u = 3'd2; c_first = 3'd1; d_second = 2'd0;
`else
        c_after_u = 3'd1; c_first = 3'd0; d_second = 2'd1;
`endif
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, B_L, 1'b0);
        checks++;
        if (COUNT !== 3'd1) begin
            failures++;
            $display("FAIL two_count_1: got %0d required 1", COUNT);
        end
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, B_U, 1'b0);
        checks++;
        if (COUNT !== c_after_u) begin
            failures++;
            $display("FAIL two_count_2: got %0d required %0d", COUNT, c_after_u);
        end
        cycle(1'b0, 4'b0000, 1'b1);
        checks++;
        if (DIR !== 2'd1 || COUNT !== c_first) begin
            failures++;
            $display("FAIL two_tick_1: DIR=%0d COUNT=%0d required 1 %0d", DIR, COUNT, c_first);
        end
        cycle(1'b0, 4'b0000, 1'b1);
        checks++;
        if (DIR !== d_second || COUNT !== 3'd0) begin
            failures++;
            $display("FAIL two_tick_2: DIR=%0d COUNT=%0d required %0d 0", DIR, COUNT, d_second);
        end
    endtask

    task automatic test_priority;
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, B_L, 1'b0);
        cycle(1'b0, 4'b0000, 1'b1);
        checks++;
        if (DIR !== 2'd1) begin
            failures++;
            $display("FAIL prio_setup: DIR=%0d required 1", DIR);
        end
        cycle(1'b0, B_U | B_R, 1'b0);
        checks++;
        if (COUNT !== 3'd1) begin
            failures++;
            $display("FAIL prio_count: got %0d required 1", COUNT);
        end
        cycle(1'b0, 4'b0000, 1'b1);
        checks++;
        if (DIR !== 2'd0 || COUNT !== 3'd0) begin
            failures++;
            $display("FAIL prio_dir: DIR=%0d COUNT=%0d required 0 0", DIR, COUNT);
        end
    endtask

`ifdef DIR_QUEUE_EN
    task automatic test_full_drop;
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, B_L, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, B_U, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, B_R, 1'b0);
        checks++;
        if (DROP !== 1'b1 || COUNT !== 3'd2) begin
            failures++;
            $display("FAIL full_drop: DROP=%0d COUNT=%0d required 1 2", DROP, COUNT);
        end
        cycle(1'b0, 4'b0000, 1'b0);
        checks++;
        if (DROP !== 1'b0) begin
            failures++;
            $display("FAIL drop_one_cycle: got %0d required 0", DROP);
        end
        cycle(1'b0, B_R, 1'b1);
        checks++;
        if (COUNT !== 3'd2 || DIR !== 2'd1 || DROP !== 1'b0) begin
            failures++;
            $display("FAIL full_push_pop: COUNT=%0d DIR=%0d DROP=%0d required 2 1 0", COUNT, DIR, DROP);
        end
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        checks++;
        if (DIR !== 2'd2 || COUNT !== 3'd0) begin
            failures++;
            $display("FAIL full_drain: DIR=%0d COUNT=%0d required 2 0", DIR, COUNT);
        end
    endtask
`else
    task automatic test_slot_overwrite;
        bit saw_drop;
        saw_drop = 1'b0;
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, B_L, 1'b0);
        saw_drop |= DROP;
        cycle(1'b0, 4'b0000, 1'b0);
        saw_drop |= DROP;
        cycle(1'b0, B_R, 1'b0);
        saw_drop |= DROP;
        checks++;
        if (COUNT !== 3'd1) begin
            failures++;
            $display("FAIL slot_count: got %0d required 1", COUNT);
        end
        cycle(1'b0, 4'b0000, 1'b1);
        saw_drop |= DROP;
        checks++;
        if (DIR !== 2'd2 || COUNT !== 3'd0) begin
            failures++;
            $display("FAIL slot_overwrite: DIR=%0d COUNT=%0d required 2 0", DIR, COUNT);
        end
        checks++;
        if (saw_drop !== 1'b0) begin
            failures++;
            $display("FAIL slot_drop: got %0d required 0", saw_drop);
        end
    endtask
`endif

    task automatic test_reset_mid_queue;
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, B_L, 1'b0);
        cycle(1'b1, B_R, 1'b1);
        checks++;
        if (COUNT !== 3'd0 || DIR !== 2'd0 || MOVE !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: COUNT=%0d DIR=%0d MOVE=%0d required 0 0 0", COUNT, DIR, MOVE);
        end
        cycle(1'b0, B_R, 1'b0);
        checks++;
        if (COUNT !== 3'd0) begin
            failures++;
            $display("FAIL reset_mid_held: COUNT=%0d required 0", COUNT);
        end
        cycle(1'b0, 4'b0000, 1'b0);
    endtask

    task automatic test_random;
        logic [3:0] btn;
        logic       tk;
        logic       rs;
        cycle(1'b1, 4'b0000, 1'b0);
        for (int n = 0; n < 1500; n++) begin
            rs  = ($urandom_range(0, 99) == 0);
            btn = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b0000;
            tk  = ($urandom_range(0, 3) == 0);
            cycle(rs, btn, tk);
            checks++;
            if (DIR !== m_dir || MOVE !== e_move || COUNT !== 3'(exp_q.size()) || DROP !== e_drop) begin
                failures++;
                $display("FAIL random_cycle_%0d: DIR=%0d MOVE=%0d COUNT=%0d DROP=%0d required %0d %0d %0d %0d",
                         n, DIR, MOVE, COUNT, DROP, m_dir, e_move, exp_q.size(), e_drop);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        RESET = 1'b1;
        {BTND, BTNR, BTNL, BTNU} = 4'b0000;
        TICK   = 1'b0;
        m_dir  = 2'd0;
        m_prev = 4'b0000;
        e_move = 1'b0;
        e_drop = 1'b0;
        #2;
        test_reset();
        test_reject_opposite();
        test_two_presses();
        test_priority();
`ifdef DIR_QUEUE_EN
        test_full_drop();
`else
        test_slot_overwrite();
`endif
        test_reset_mid_queue();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
